// File: rtl/aes_ct_uart_tx.sv
// aes_ct_uart_tx
// Captures each AES ciphertext when the core's busy flag falls and sends it
// to the capture host as an 18-byte 8N1 frame:
// sync byte, 16 ciphertext bytes (MSB byte first), XOR checksum.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | line idle high, waiting for a busy_i falling edge
// START   | driving the start bit (0) of byte byte_idx
// DATA    | driving data bit bit_idx of byte byte_idx, LSB first
// STOP    | driving the stop bit (1); last byte returns to IDLE
`timescale 1ns/1ps

module aes_ct_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         busy_i,
  input  logic [127:0] data_i,
  output logic         uart_tx_o,
  output logic         tx_busy_o,
  output logic         overrun_o,
  output logic [15:0]  frame_cnt_o
);

  // Bit timer counts down from CLKS_PER_BIT-1 to zero, then reloads, so every
  // bit is exactly CLKS_PER_BIT cycles and no error accumulates across a frame.
  localparam int unsigned   TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LAST_BYTE = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_nxt;
  logic [TW-1:0]   timer_q, timer_nxt;
  logic [2:0]      bit_idx_q, bit_idx_nxt;
  logic [4:0]      byte_idx_q, byte_idx_nxt;

  logic            busy_d;
  logic [127:0]    ct_reg;
  logic [7:0]      chk_reg;
  logic [7:0]      chk_comb;

  logic            completion;
  logic            capture;
  logic            bit_tc;
  logic            frame_end;

  logic [4:0]      byte_sel;
  logic [7:0]      ct_byte;
  logic [7:0]      cur_byte;
  logic            tx_nxt;

  logic            tx_q;
  logic            tx_busy_q;
  logic            overrun_q;
  logic [15:0]     frame_cnt_q;

  assign completion = busy_d & ~busy_i;
  assign capture    = completion & (state_q == ST_IDLE);
  assign bit_tc     = (timer_q == '0);

  // Checksum of the incoming ciphertext, latched alongside it on capture.
  always_comb begin
    chk_comb = 8'h00;
    for (int i = 0; i < 16; i++) begin
      chk_comb = chk_comb ^ data_i[8*i +: 8];
    end
  end

  // Next-state, bit timer and byte/bit index sequencing.
  always_comb begin
    state_nxt    = state_q;
    timer_nxt    = timer_q;
    bit_idx_nxt  = bit_idx_q;
    byte_idx_nxt = byte_idx_q;
    frame_end    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_nxt    = ST_START;
          timer_nxt    = BIT_LOAD;
          bit_idx_nxt  = 3'd0;
          byte_idx_nxt = 5'd0;
        end
      end
      ST_START: begin
        if (bit_tc) begin
          state_nxt   = ST_DATA;
          timer_nxt   = BIT_LOAD;
          bit_idx_nxt = 3'd0;
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
      ST_DATA: begin
        if (bit_tc) begin
          timer_nxt = BIT_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_nxt = ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx_q + 3'd1;
          end
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
      ST_STOP: begin
        if (bit_tc) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_nxt = ST_IDLE;
            frame_end = 1'b1;
          end else begin
            state_nxt    = ST_START;
            timer_nxt    = BIT_LOAD;
            byte_idx_nxt = byte_idx_q + 5'd1;
          end
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Select the byte being sent next cycle and the line level it implies.
  // ct_reg/chk_reg are only read once the start bit is out, so the values
  // latched on the capture edge are always the ones used.
  always_comb begin
    byte_sel = 5'd16 - byte_idx_nxt;
    ct_byte  = ct_reg[{byte_sel[3:0], 3'b000} +: 8];
    if (byte_idx_nxt == 5'd0) begin
      cur_byte = SYNC_BYTE;
    end else if (byte_idx_nxt == LAST_BYTE) begin
      cur_byte = chk_reg;
    end else begin
      cur_byte = ct_byte;
    end
    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = cur_byte[bit_idx_nxt];
      default:  tx_nxt = 1'b1;
    endcase
  end

  // FSM state and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 5'd0;
    end else begin
      state_q    <= state_nxt;
      timer_q    <= timer_nxt;
      bit_idx_q  <= bit_idx_nxt;
      byte_idx_q <= byte_idx_nxt;
    end
  end

  // Busy edge detector and ciphertext/checksum capture; held while a frame runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_d  <= 1'b0;
      ct_reg  <= '0;
      chk_reg <= 8'h00;
    end else begin
      busy_d <= busy_i;
      if (capture) begin
        ct_reg  <= data_i;
        chk_reg <= chk_comb;
      end
    end
  end

  // Registered line and busy flag; reset forces the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      tx_q      <= tx_nxt;
      tx_busy_q <= (state_nxt != ST_IDLE);
    end
  end

  // Sticky overrun (any completion outside IDLE, including the frame's last
  // cycle) and the wrapping completed-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      if (completion && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (frame_end) begin
        frame_cnt_q <= frame_cnt_q + 16'h0001;
      end
    end
  end

  assign uart_tx_o   = tx_q;
  assign tx_busy_o   = tx_busy_q;
  assign overrun_o   = overrun_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_aes_ct_uart_tx.sv
// Testbench for aes_ct_uart_tx: scoreboard of expected UART bytes, filled when
// a completion is driven and drained by a line monitor decoding 8N1.
`timescale 1ns/1ps

module tb_aes_ct_uart_tx;

  localparam int CPB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         busy_i = 1'b0;
  logic [127:0] data_i = '0;
  logic         uart_tx_o;
  logic         tx_busy_o;
  logic         overrun_o;
  logic [15:0]  frame_cnt_o;

  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   exp_q[$];
  logic [15:0]  exp_frames = 16'h0000;

  aes_ct_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy_i      (busy_i),
    .data_i      (data_i),
    .uart_tx_o   (uart_tx_o),
    .tx_busy_o   (tx_busy_o),
    .overrun_o   (overrun_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [127:0] d);
    logic [7:0] c;
    c = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 15; i >= 0; i--) begin
      exp_q.push_back(d[8*i +: 8]);
      c = c ^ d[8*i +: 8];
    end
    exp_q.push_back(c);
  endtask

  // Called at a negedge; busy falls one cycle later, returns one cycle after
  // that, i.e. on the first negedge after the capture edge.
  task automatic done_pulse(input logic [127:0] d, input bit accept);
    busy_i = 1'b1;
    @(negedge clk);
    busy_i = 1'b0;
    data_i = d;
    if (accept) push_frame(d);
    @(negedge clk);
    if (accept) begin
      chk("busy_rise", {31'b0, tx_busy_o}, 32'd1);
      chk("start_bit", {31'b0, uart_tx_o}, 32'd0);
    end
  endtask

  task automatic run_out(output int n);
    n = 0;
    while (tx_busy_o === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("frame_timeout", {31'b0, (n < 2000)}, 32'd1);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
  endtask

  // Line monitor: every bit must hold CPB samples; frame checked as start,
  // LSB-first data, stop against the scoreboard head.
  initial begin : monitor
    logic [9:0] pat;
    logic       hold_ok;
    logic       abort;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx_o === 1'b0) begin
        pat     = '0;
        hold_ok = 1'b1;
        abort   = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (rst_n !== 1'b1) abort = 1'b1;
            if (s == 0) pat[b] = uart_tx_o;
            else if (uart_tx_o !== pat[b]) hold_ok = 1'b0;
          end
        end
        if (!abort) begin
          chk("bit_hold", {31'b0, hold_ok}, 32'd1);
          chk("sb_nonempty", {31'b0, (exp_q.size() != 0)}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("byte", {22'b0, pat}, {22'b0, 1'b1, e, 1'b0});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic line_high;
    logic [127:0] d;

    // Reset held with busy toggling: no line activity.
    line_high = 1'b1;
    for (int i = 0; i < 20; i++) begin
      busy_i = i[0];
      @(negedge clk);
      if (uart_tx_o !== 1'b1) line_high = 1'b0;
    end
    chk("rst_line_idle", {31'b0, line_high}, 32'd1);
    chk("rst_tx_busy", {31'b0, tx_busy_o}, 32'd0);
    chk("rst_overrun", {31'b0, overrun_o}, 32'd0);
    chk("rst_frame_cnt", {16'b0, frame_cnt_o}, 32'd0);
    busy_i = 1'b0;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {31'b0, tx_busy_o}, 32'd0);

    // Basic frame.
    done_pulse(128'h0102030405060708090A0B0C0D0E0F10, 1'b1);
    run_out(n);
    exp_frames = exp_frames + 16'd1;
    chk("frame_len", n, 32'd720);
    chk("frame_cnt_basic", {16'b0, frame_cnt_o}, {16'b0, exp_frames});
    chk("ovr_basic", {31'b0, overrun_o}, 32'd0);

    // Overrun: second completion 100 cycles in is dropped.
    repeat (5) @(negedge clk);
    d = 128'h00112233445566778899AABBCCDDEEFF;
    done_pulse(d, 1'b1);
    repeat (98) @(negedge clk);
    chk("ovr_pre", {31'b0, overrun_o}, 32'd0);
    done_pulse({128{1'b1}}, 1'b0);
    chk("ovr_busy_hold", {31'b0, tx_busy_o}, 32'd1);
    chk("ovr_set", {31'b0, overrun_o}, 32'd1);
    run_out(n);
    exp_frames = exp_frames + 16'd1;
    chk("frame_cnt_ovr", {16'b0, frame_cnt_o}, {16'b0, exp_frames});
    repeat (20) @(negedge clk);
    chk("ovr_sticky", {31'b0, overrun_o}, 32'd1);
    chk("ovr_no_refire", {31'b0, tx_busy_o}, 32'd0);

    // Reset mid-frame at cycle 300: line returns high asynchronously.
    done_pulse('0, 1'b1);
    repeat (298) @(negedge clk);
    chk("pre_rst_line", {31'b0, uart_tx_o}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_line", {31'b0, uart_tx_o}, 32'd1);
    chk("async_busy", {31'b0, tx_busy_o}, 32'd0);
    chk("async_cnt", {16'b0, frame_cnt_o}, 32'd0);
    chk("async_ovr", {31'b0, overrun_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    exp_q.delete();
    exp_frames = 16'h0000;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    done_pulse(d, 1'b1);
    run_out(n);
    exp_frames = exp_frames + 16'd1;
    chk("frame_len_rst", n, 32'd720);
    chk("frame_cnt_rst", {16'b0, frame_cnt_o}, {16'b0, exp_frames});

    // Three completions spaced 800 cycles apart.
    for (int k = 0; k < 3; k++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      done_pulse(d, 1'b1);
      exp_frames = exp_frames + 16'd1;
      repeat (798) @(negedge clk);
    end
    chk("b2b_cnt", {16'b0, frame_cnt_o}, {16'b0, exp_frames});
    chk("b2b_ovr", {31'b0, overrun_o}, 32'd0);
    chk("b2b_drained", exp_q.size(), 32'd0);

    // Counter wrap, plus a completion coinciding with the STOP->IDLE edge.
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    exp_frames = 16'hFFFF;
    @(negedge clk);
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    done_pulse(d, 1'b1);
    repeat (718) @(negedge clk);
    chk("edge_ovr_pre", {31'b0, overrun_o}, 32'd0);
    done_pulse(~d, 1'b0);
    exp_frames = exp_frames + 16'd1;
    chk("edge_busy_fell", {31'b0, tx_busy_o}, 32'd0);
    chk("edge_ovr_set", {31'b0, overrun_o}, 32'd1);
    chk("wrap_cnt", {16'b0, frame_cnt_o}, {16'b0, exp_frames});
    repeat (60) @(negedge clk);
    chk("edge_no_capture", {31'b0, tx_busy_o}, 32'd0);
    chk("edge_drained", exp_q.size(), 32'd0);
    chk("edge_line_idle", {31'b0, uart_tx_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
